sdio_frame_rx: RTL

SDIO_FRAME_RX -- requirements
Module: sdio_frame_rx

---
 rtl/sdio_frame_rx_if.sv | 24 ++
 rtl/sdio_frame_rx.sv | 118 +++++++++++
 2 files changed

// File: rtl/sdio_frame_rx_if.sv
// Output stream of the SDIO frame receiver: head-of-FIFO payload, parity flag
// and the valid/ready handshake between the receiver and its consumer.
interface sdio_frame_rx_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] out_data;
    logic              out_perr;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_perr,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_perr,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/sdio_frame_rx.sv
// Serial frame receiver: start bit, MSB-first payload, even parity, stop bit,
// with received frames buffered in a small FIFO behind a valid/ready port.
//
// state      | meaning
// -----------+----------------------------------------------------------
// UNARMED    | after reset or a framing error; waits for a 1 on the line
// IDLE       | line armed; a 0 sample is taken as the start bit
// DATA       | shifting payload bits, bit_cnt counts down to 0
// PARITY     | sampling the parity bit, latching the parity error flag
// STOP       | sampling the stop bit; 1 pushes the frame, 0 flags an error
module sdio_frame_rx #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            sclk,
    input  logic            rst,
    input  logic            sdio,
    sdio_frame_rx_if.master out_if,
    output logic            frame_err,
    output logic            overflow,
    output logic            busy
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [2:0] ST_UNARMED = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_PARITY  = 3'd3;
    localparam logic [2:0] ST_STOP    = 3'd4;

    logic [2:0]        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              perr_q;

    logic [DATA_W:0]   mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              push_en;

    // Receive FSM
    always_ff @(posedge sclk) begin
        if (rst) begin
            state     <= ST_UNARMED;
            bit_cnt   <= '0;
            shift_reg <= '0;
            perr_q    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                ST_UNARMED: begin
                    if (sdio) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (!sdio) begin
                        state   <= ST_DATA;
                        bit_cnt <= CNT_W'(DATA_W - 1);
                    end
                end
                ST_DATA: begin
                    shift_reg <= {shift_reg[DATA_W-2:0], sdio};
                    bit_cnt   <= bit_cnt - 1'b1;
                    if (bit_cnt == '0) state <= ST_PARITY;
                end
                ST_PARITY: begin
                    perr_q <= (^shift_reg) ^ sdio;
                    state  <= ST_STOP;
                end
                ST_STOP: begin
                    if (sdio) begin
                        state <= ST_IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= ST_UNARMED;
                    end
                end
                default: state <= ST_UNARMED;
            endcase
        end
    end

    assign busy = (state == ST_DATA) || (state == ST_PARITY) || (state == ST_STOP);

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push       = (state == ST_STOP) && sdio;
    assign pop        = out_if.out_valid && out_if.out_ready;
    // A pop frees the head slot at the same edge, so a full FIFO still accepts.
    assign push_en    = push && (!fifo_full || pop);

    always_ff @(posedge sclk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge sclk) begin
        if (push_en) mem[wr_ptr[PTR_W-1:0]] <= {shift_reg, perr_q};
    end

    // Head is forced to zero while empty so stale entries never show.
    assign out_if.out_valid = !fifo_empty;
    assign {out_if.out_data, out_if.out_perr} =
        fifo_empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
endmodule
